inst_encoder: RTL

- Streaming RV32I instruction encoder, the inverse of the ID decoder: takes decoded fields (format, opcode, funct3/funct7, rd/rs1/rs2, immediate) and packs them into a 32-bit instruction word.
- Emits each word with an auto-incrementing byte address on a valid/ready write interface.
- Sits in front of inst_mem's load/write port as the program loader, and in benches as a golden encoder for ID round-trip checks.

---
 rtl/inst_enc_pkg.sv | 36 +++
 rtl/inst_enc_pack.sv | 62 ++++++
 rtl/inst_encoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/inst_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder and the ID decoder.
// Contents:
//   - instruction format codes (FMT_R..FMT_J); 6 and 7 are illegal
//   - RV32I major opcode constants
//   - encoder FSM state encoding
//   - fits_signed: immediate range helper used by the optional range checks
package inst_enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_VALID = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // True when v is representable as a signed value whose sign bit and all
    // bits above it are covered by 'mask' (e.g. 32'hFFFF_F800 for 12 bits):
    // the masked bits must be all zeros or all ones.
    function automatic logic fits_signed(input logic [31:0] v, input logic [31:0] mask);
        logic [31:0] hi;
        hi = v & mask;
        return (hi == 32'd0) || (hi == mask);
    endfunction

endpackage

// File: rtl/inst_enc_pack.sv
// inst_pack: combinational RV32I field packer.
// Takes the decoded field bundle and format code and produces the 32-bit
// instruction word plus a 'legal' flag.
// Ports: fmt, opcode, funct3, funct7, rd, rs1, rs2, imm (inputs);
//        inst (packed word), legal (bundle may be emitted).
// Build option: INST_ENC_CHECK_EN adds immediate-range and opcode[1:0]
// checks that clear 'legal'; without it out-of-range bits are truncated.
module inst_pack
    import inst_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        legal
);

    logic fmt_ok_s;
    logic range_ok_s;

    // Standard RV32I packing per format; illegal formats produce a zero word.
    always_comb begin
        inst     = 32'd0;
        fmt_ok_s = 1'b1;
        case (fmt)
            FMT_R:   inst = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   inst = {imm[31:12], rd, opcode};
            FMT_J:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: begin
                inst     = 32'd0;
                fmt_ok_s = 1'b0;
            end
        endcase
    end

`ifdef INST_ENC_CHECK_EN
    // Immediate range and opcode sanity checks.
    always_comb begin
        range_ok_s = (opcode[1:0] == 2'b11);
        case (fmt)
            FMT_I, FMT_S: range_ok_s = range_ok_s && fits_signed(imm, 32'hFFFF_F800);
            FMT_B:        range_ok_s = range_ok_s && fits_signed(imm, 32'hFFFF_F000) && !imm[0];
            FMT_J:        range_ok_s = range_ok_s && fits_signed(imm, 32'hFFF0_0000) && !imm[0];
            FMT_U:        range_ok_s = range_ok_s && (imm[11:0] == 12'd0);
            default:      range_ok_s = range_ok_s;
        endcase
    end
`else
    assign range_ok_s = 1'b1;
`endif

    assign legal = fmt_ok_s && range_ok_s;

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: streaming RV32I instruction encoder / program loader.
// Accepts decoded field bundles on a valid/ready input, packs them via
// inst_pack, and emits each word with an auto-incrementing byte address on
// a valid/ready output backed by a single output register (full throughput).
// Ports:
//   clk, rst (async active-low)
//   in_valid/in_ready, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm
//   out_valid/out_ready, out_inst, out_addr
//   count (handshakes completed), full (DEPTH words emitted, terminal),
//   err (sticky: illegal fmt or, with INST_ENC_CHECK_EN, range failure)
// Parameters: BASE_ADDR (first word address), DEPTH (words before full).
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic [16:0] count,
    output logic        full,
    output logic        err
);

    localparam logic [16:0] DEPTH_C = 17'(DEPTH);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        out_valid_r;
    logic [31:0] out_inst_r;
    logic [31:0] out_addr_r;
    logic [31:0] wr_ptr_r;
    logic [16:0] count_r;
    logic [16:0] accepted_r;
    logic        full_r;
    logic        err_r;

    logic [31:0] word_s;
    logic        legal_s;
    logic        accept_s;
    logic        acc_legal_s;
    logic        acc_illegal_s;
    logic        out_hs_s;

    inst_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm    (imm),
        .inst   (word_s),
        .legal  (legal_s)
    );

    // Stop accepting as soon as DEPTH legal words are in, even while the
    // last one is still waiting for its output handshake.
    assign in_ready      = (state_r != ST_FULL) && (accepted_r != DEPTH_C) &&
                           (!out_valid_r || out_ready);
    assign accept_s      = in_valid && in_ready;
    assign acc_legal_s   = accept_s && legal_s;
    assign acc_illegal_s = accept_s && !legal_s;
    assign out_hs_s      = out_valid_r && out_ready;

    // Next-state logic for the output register occupancy FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (acc_legal_s) state_nxt_s = ST_VALID;
                else             state_nxt_s = ST_EMPTY;
            end
            ST_VALID: begin
                if (acc_legal_s)                  state_nxt_s = ST_VALID;
                else if (!out_hs_s)               state_nxt_s = ST_VALID;
                else if (accepted_r == DEPTH_C)   state_nxt_s = ST_FULL;
                else                              state_nxt_s = ST_EMPTY;
            end
            ST_FULL:  state_nxt_s = ST_FULL;
            default:  state_nxt_s = ST_EMPTY;
        endcase
    end

    // Output register, write pointer, counters and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            out_inst_r  <= 32'd0;
            out_addr_r  <= BASE_ADDR;
            wr_ptr_r    <= BASE_ADDR;
            count_r     <= 17'd0;
            accepted_r  <= 17'd0;
            full_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (acc_legal_s) begin
                // A new word overwrites the register in the same edge as
                // the old one's handshake, so there is no bubble.
                out_inst_r <= word_s;
                out_addr_r <= wr_ptr_r;
                wr_ptr_r   <= wr_ptr_r + 32'd4;
                accepted_r <= accepted_r + 17'd1;
            end
            if (acc_illegal_s) begin
                err_r <= 1'b1;
            end
            if (out_hs_s) begin
                count_r <= count_r + 17'd1;
            end
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s == ST_VALID);
            full_r      <= (state_nxt_s == ST_FULL);
        end
    end

    assign out_valid = out_valid_r;
    assign out_inst  = out_inst_r;
    assign out_addr  = out_addr_r;
    assign count     = count_r;
    assign full      = full_r;
    assign err       = err_r;

endmodule
